// File: rtl/queue_stream_tx_pkg.sv
// Shared types and constants for the queue_stream_tx circular-buffer queue.
// Default sizes are reused by benches that build their own reference queues.
package queue_stream_tx_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 1024;

  // Output register occupancy: the RAM read register either holds the head word or not.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } out_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/queue_stream_tx_if.sv
// Producer write strobe, consumer valid/ready stream and status flags of queue_stream_tx.
interface queue_stream_tx_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
);
  import queue_stream_tx_pkg::*;

  localparam int ADDR_W = clog2(DEPTH);

  logic              flush;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              full;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              ovf_clr;

  modport master (
    output flush, wr_en, wr_data, out_ready, ovf_clr,
    input  full, out_valid, out_data, level, overflow
  );

  modport slave (
    input  flush, wr_en, wr_data, out_ready, ovf_clr,
    output full, out_valid, out_data, level, overflow
  );

endinterface

// File: rtl/queue_stream_tx_sync_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port whose
// registered read data doubles as the queue's output register.
module sync_ram_1r1w
  import queue_stream_tx_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the read
  // register is cleared, and stale entries are never read because of ram_count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/queue_stream_tx.sv
// Circular-buffer queue with a first-word-fall-through valid/ready drain side and a
// sticky overflow flag for pushes dropped while full.
module queue_stream_tx
  import queue_stream_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  queue_stream_tx_if.slave bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  out_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  ram_count_q, ram_count_d;
  logic              full_q;
  logic [CNT_W-1:0]  level_q;
  logic              overflow_q;
  logic              push;
  logic              rd_en;
  logic              drop;

  assign push  = bus.wr_en & ~full_q & ~bus.flush;
  // A push in a flush cycle is discarded silently, so only non-flush drops are flagged.
  assign drop  = bus.wr_en & full_q & ~bus.flush;
  assign rd_en = (ram_count_q != '0) & ((state_q == ST_EMPTY) | bus.out_ready) & ~bus.flush;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ram_count_d = ram_count_q + CNT_W'(push) - CNT_W'(rd_en);
    if (bus.flush) begin
      state_d     = ST_EMPTY;
      ram_count_d = '0;
    end else if (rd_en) begin
      state_d = ST_VALID;
    end else if (bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      full_q      <= 1'b0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_count_q <= ram_count_d;
      full_q      <= (ram_count_d == CNT_W'(DEPTH));
      level_q     <= ram_count_d + CNT_W'(state_d == ST_VALID);
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)  wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (rd_en) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      if (drop)             overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

  sync_ram_1r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push & rst_n),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (bus.out_data)
  );

  assign bus.out_valid = (state_q == ST_VALID);
  assign bus.full      = full_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_queue_stream_tx.sv
// Directed bench for queue_stream_tx (DEPTH=4): a scoreboard queue is filled as words are
// pushed and a negedge monitor pops and compares on every out_valid & out_ready handshake.
module tb_queue_stream_tx;
  import queue_stream_tx_pkg::*;

  localparam int WIDTH  = DEF_WIDTH;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  queue_stream_tx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  queue_stream_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] exp_q [$];
  bit               mon_en = 1'b0;
  bit               prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes handshakes and checks that a stalled head word does not move.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold)
        check("hold_stable", {31'd0, bus.out_valid, bus.out_data}, {31'd0, 1'b1, prev_data});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 64'(exp_q.size()), 64'd1);
        else                   check("stream_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
      end
      prev_hold = bus.out_valid && !bus.out_ready && !bus.flush;
      prev_data = bus.out_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] data, input bit accepted);
    bus.wr_en   = 1'b1;
    bus.wr_data = data;
    if (accepted) exp_q.push_back(data);
    tick();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    int full_cnt;

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;

    // Reset held for two edges
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_full",      64'(bus.full),      64'd0);
    check("rst_level",     64'(bus.level),     64'd0);
    check("rst_overflow",  64'(bus.overflow),  64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single word latency
    bus.out_ready = 1'b1;
    push(32'hDEADBEEF, 1'b1);
    check("lat_level_t1", 64'(bus.level),     64'd1);
    check("lat_valid_t1", 64'(bus.out_valid), 64'd0);
    tick();
    check("lat_valid_t2", 64'(bus.out_valid), 64'd1);
    check("lat_data_t2",  64'(bus.out_data),  64'hDEADBEEF);
    check("lat_level_t2", 64'(bus.level),     64'd1);
    tick();
    check("lat_level_t3", 64'(bus.level),     64'd0);
    check("lat_valid_t3", 64'(bus.out_valid), 64'd0);

    // Fill to DEPTH+1, sixth push dropped
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      push(WIDTH'(i), i <= 5);
      if (i == 5) begin
        check("fill_full_after5",  64'(bus.full),     64'd1);
        check("fill_level_after5", 64'(bus.level),    64'd5);
        check("fill_ovf_after5",   64'(bus.overflow), 64'd0);
      end
    end
    check("fill_overflow", 64'(bus.overflow), 64'd1);
    check("fill_level",    64'(bus.level),    64'd5);
    check("fill_full",     64'(bus.full),     64'd1);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("drain_valid", 64'(bus.out_valid), 64'd0);
    check("drain_level", 64'(bus.level),     64'd0);
    check("drain_full",  64'(bus.full),      64'd0);
    check("drain_sb",    64'(exp_q.size()),  64'd0);

    // Toggling out_ready against a full queue
    bus.out_ready = 1'b0;
    for (int i = 10; i < 15; i++) push(WIDTH'(i), 1'b1);
    check("toggle_full", 64'(bus.full), 64'd1);
    for (int c = 0; c < 16; c++) begin
      bus.out_ready = (c % 2 == 0);
      tick();
    end
    bus.out_ready = 1'b0;
    check("toggle_valid", 64'(bus.out_valid), 64'd0);
    check("toggle_sb",    64'(exp_q.size()),  64'd0);
    check("toggle_level", 64'(bus.level),     64'd0);

    // Mid-stream flush with a simultaneous push
    for (int i = 20; i < 23; i++) push(WIDTH'(i), 1'b1);
    tick();
    check("pre_flush_valid",    64'(bus.out_valid), 64'd1);
    check("pre_flush_overflow", 64'(bus.overflow),  64'd1);
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hBAD0BAD0;
    tick();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    exp_q.delete();
    check("flush_level",    64'(bus.level),     64'd0);
    check("flush_valid",    64'(bus.out_valid), 64'd0);
    check("flush_overflow", 64'(bus.overflow),  64'd1);
    check("flush_full",     64'(bus.full),      64'd0);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("flush_no_word", 64'(bus.out_valid), 64'd0);

    // Overflow set beats clear, then clear alone
    bus.out_ready = 1'b0;
    for (int i = 30; i < 35; i++) push(WIDTH'(i), 1'b1);
    check("ovf_full", 64'(bus.full), 64'd1);
    bus.ovf_clr = 1'b1;
    push(WIDTH'(35), 1'b0);
    bus.ovf_clr = 1'b0;
    check("ovf_set_wins", 64'(bus.overflow), 64'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", 64'(bus.overflow), 64'd0);
    bus.out_ready = 1'b1;
    repeat (7) tick();
    check("ovf_drain_sb",    64'(exp_q.size()),  64'd0);
    check("ovf_drain_valid", 64'(bus.out_valid), 64'd0);

    // Sustained streaming of 1000 words
    low_cnt  = 0;
    full_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      push(WIDTH'(i), 1'b1);
      if (i >= 1 && !bus.out_valid) low_cnt++;
      if (bus.full) full_cnt++;
    end
    check("stream_valid_gaps", 64'(low_cnt),  64'd0);
    check("stream_full_seen",  64'(full_cnt), 64'd0);
    repeat (4) tick();
    check("stream_sb",    64'(exp_q.size()),  64'd0);
    check("stream_valid", 64'(bus.out_valid), 64'd0);
    check("stream_level", 64'(bus.level),     64'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
